// File: rtl/date_counter_if.sv
// Date bus between the calendar stage and its producer/consumer.
// Carries the load/tick controls and load data into the counter, and the
// current date, display bus, end-of-century flag and load error out of it.
// master : drives load, enable, hourCount, minCount, data_day/month/year
// slave  : date_counter side, drives day, month, year, databus, yearCount,
//          load_err (and weekday when DATE_WEEKDAY_EN is defined)
// Optional feature macro: DATE_WEEKDAY_EN (adds weekday[2:0]).
interface date_counter_if;
   logic        load;
   logic        enable;
   logic        hourCount;
   logic        minCount;
   logic [4:0]  data_day;
   logic [3:0]  data_month;
   logic [6:0]  data_year;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [6:0]  year;
   logic [15:0] databus;
   logic        yearCount;
   logic        load_err;
`ifdef DATE_WEEKDAY_EN
   logic [2:0]  weekday;
`endif

   modport master (
      output load, enable, hourCount, minCount, data_day, data_month, data_year,
`ifdef DATE_WEEKDAY_EN
      input  weekday,
`endif
      input  day, month, year, databus, yearCount, load_err
   );

   modport slave (
      input  load, enable, hourCount, minCount, data_day, data_month, data_year,
`ifdef DATE_WEEKDAY_EN
      output weekday,
`endif
      output day, month, year, databus, yearCount, load_err
   );
endinterface

// File: rtl/date_counter.sv
// Calendar stage downstream of the 24-hour counter. Holds day/month/year
// (2000..2000+YEAR_MAX) with month lengths and leap years; advances when the
// hour stage wraps 23->0 (hourCount & minCount) and accepts checked loads.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-low (date -> 01/01/2000)
//   bus    date_counter_if.slave: load/enable/hourCount/minCount/data_* in;
//          day/month/year/load_err registered out; databus and yearCount
//          combinational from the registers
// Optional feature macro: DATE_WEEKDAY_EN adds a registered weekday
// output (0=Sun..6=Sat) that tracks ticks and is recomputed on a valid load.
module date_counter #(
   parameter int unsigned YEAR_MAX = 99
) (
   input logic           clk,
   input logic           rst_n,
   date_counter_if.slave bus
);

   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;
   localparam int unsigned YEAR_W  = 7;
   localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);

   // Days in month m of year offset y; 0 for an illegal month.
   function automatic logic [DAY_W-1:0] mlen(input logic [MONTH_W-1:0] m,
                                             input logic [YEAR_W-1:0]  y);
      logic [DAY_W-1:0] len;
      case (m)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
         4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
         4'd2:    len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default: len = 5'd0;
      endcase
      return len;
   endfunction

   logic [DAY_W-1:0]   day_q,   day_d;
   logic [MONTH_W-1:0] month_q, month_d;
   logic [YEAR_W-1:0]  year_q,  year_d;
   logic               load_err_q, load_err_d;
   logic               tick_c;
   logic               load_ok_c;

   assign tick_c = bus.hourCount & bus.minCount & ~bus.load;

   // A month of 0 yields mlen 0, so the day bound rejects it as well.
   assign load_ok_c = (bus.data_month >= 4'd1) && (bus.data_month <= 4'd12) &&
                      (bus.data_year <= YEAR_LAST) && (bus.data_day >= 5'd1) &&
                      (bus.data_day <= mlen(bus.data_month, bus.data_year));

`ifdef DATE_WEEKDAY_EN
   logic [2:0]  weekday_q, weekday_d;
   logic [8:0]  doy_base_c;
   logic [15:0] days_c;
   logic [2:0]  load_wday_c;

   // Days in the year before the first of the loaded month (non-leap).
   always_comb begin
      doy_base_c = 9'd0;
      case (bus.data_month)
         4'd2:    doy_base_c = 9'd31;
         4'd3:    doy_base_c = 9'd59;
         4'd4:    doy_base_c = 9'd90;
         4'd5:    doy_base_c = 9'd120;
         4'd6:    doy_base_c = 9'd151;
         4'd7:    doy_base_c = 9'd181;
         4'd8:    doy_base_c = 9'd212;
         4'd9:    doy_base_c = 9'd243;
         4'd10:   doy_base_c = 9'd273;
         4'd11:   doy_base_c = 9'd304;
         4'd12:   doy_base_c = 9'd334;
         default: doy_base_c = 9'd0;
      endcase
   end

   // Days since 01/01/2000: leap years before year y number ceil(y/4),
   // plus this year's Feb 29 once past February. 2000-01-01 was a Saturday.
   assign days_c = 16'(doy_base_c) + 16'(bus.data_day) - 16'd1 +
                   16'(bus.data_year) * 16'd365 +
                   16'((8'(bus.data_year) + 8'd3) >> 2) +
                   16'((bus.data_year[1:0] == 2'b00) && (bus.data_month > 4'd2));
   assign load_wday_c = 3'((days_c + 16'd6) % 16'd7);
`endif

   // Next-state: load (checked) has priority over the rollover tick.
   always_comb begin
      day_d      = day_q;
      month_d    = month_q;
      year_d     = year_q;
      load_err_d = 1'b0;
`ifdef DATE_WEEKDAY_EN
      weekday_d  = weekday_q;
`endif
      if (bus.load) begin
         if (load_ok_c) begin
            day_d   = bus.data_day;
            month_d = bus.data_month;
            year_d  = bus.data_year;
`ifdef DATE_WEEKDAY_EN
            weekday_d = load_wday_c;
`endif
         end else begin
            load_err_d = 1'b1;
         end
      end else if (tick_c) begin
`ifdef DATE_WEEKDAY_EN
         weekday_d = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
`endif
         if (day_q < mlen(month_q, year_q)) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (month_q < 4'd12) begin
               month_d = month_q + 4'd1;
            end else begin
               month_d = 4'd1;
               year_d  = (year_q < YEAR_LAST) ? year_q + 7'd1 : 7'd0;
            end
         end
      end
   end

   // Date registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_q      <= 5'd1;
         month_q    <= 4'd1;
         year_q     <= 7'd0;
         load_err_q <= 1'b0;
`ifdef DATE_WEEKDAY_EN
         weekday_q  <= 3'd6;
`endif
      end else begin
         day_q      <= day_d;
         month_q    <= month_d;
         year_q     <= year_d;
         load_err_q <= load_err_d;
`ifdef DATE_WEEKDAY_EN
         weekday_q  <= weekday_d;
`endif
      end
   end

   assign bus.day       = day_q;
   assign bus.month     = month_q;
   assign bus.year      = year_q;
   assign bus.load_err  = load_err_q;
   assign bus.databus   = bus.enable ? {year_q, month_q, day_q} : 16'h0000;
   assign bus.yearCount = (day_q == 5'd31) && (month_q == 4'd12) && (year_q == YEAR_LAST);
`ifdef DATE_WEEKDAY_EN
   assign bus.weekday   = weekday_q;
`endif

endmodule
